// File: rtl/ws2811_serial_tx.sv
// WS2811 single-wire bit encoder: turns a 24-bit LED word into high/low pulses,
// generates the latch low period, and reports completion to the controller FSM.
module ws2811_serial_tx #(
  parameter int unsigned T0H_CYCLES   = 20,
  parameter int unsigned T1H_CYCLES   = 40,
  parameter int unsigned BIT_CYCLES   = 63,
  parameter int unsigned RESET_CYCLES = 3000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send_data,
  input  logic        serial_reset,
  input  logic [23:0] data,
  output logic        dout,
  output logic        word_sent,
  output logic        serial_reset_done,
  output logic [1:0]  db_estado
);

  localparam int unsigned MAX_CYCLES = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] T0H      = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H      = CNT_W'(T1H_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BIT   = 2'b01,
    ST_LATCH = 2'b10
  } state_t;

  state_t           state;
  logic [23:0]      shreg;
  logic [4:0]       bit_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] cyc_inc;
  logic [CNT_W-1:0] t_high;

  assign cyc_inc   = cyc_cnt + CNT_W'(1);
  assign t_high    = shreg[23] ? T1H : T0H;
  assign db_estado = state;

  // Outputs are registered from the next-state values so dout, the pulses and
  // db_estado all change on the same edge as the state they belong to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      shreg             <= '0;
      bit_cnt           <= '0;
      cyc_cnt           <= '0;
      dout              <= 1'b0;
      word_sent         <= 1'b0;
      serial_reset_done <= 1'b0;
    end else begin
      word_sent         <= 1'b0;
      serial_reset_done <= 1'b0;
      dout              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (serial_reset) begin
            state             <= ST_LATCH;
            cyc_cnt           <= '0;
            serial_reset_done <= (RST_LAST == '0);
          end else if (send_data) begin
            state   <= ST_BIT;
            shreg   <= data;
            bit_cnt <= 5'd23;
            cyc_cnt <= '0;
            // Every high time is non-zero, so a new bit always starts high.
            dout    <= 1'b1;
          end
        end

        ST_BIT: begin
          if (cyc_cnt == BIT_LAST) begin
            if (bit_cnt != 5'd0) begin
              shreg   <= {shreg[22:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
              cyc_cnt <= '0;
              dout    <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cyc_cnt   <= cyc_inc;
            dout      <= (cyc_inc < t_high);
            word_sent <= (cyc_inc == BIT_LAST) && (bit_cnt == 5'd0);
          end
        end

        ST_LATCH: begin
          if (!serial_reset || (cyc_cnt == RST_LAST)) begin
            state <= ST_IDLE;
          end else begin
            cyc_cnt           <= cyc_inc;
            serial_reset_done <= (cyc_inc == RST_LAST);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2811_serial_tx.sv
// Self-checking bench for ws2811_serial_tx: cycle-indexed stimulus tables, per-cycle
// output logs, and a pulse scoreboard derived from the LED word.
module tb_ws2811_serial_tx;

  localparam int BITC = 63;
  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int RSTC = 3000;
  localparam int NLOG = 3100;

  logic        clock = 1'b0;
  logic        reset;
  logic        send_data;
  logic        serial_reset;
  logic [23:0] data;
  logic        dout;
  logic        word_sent;
  logic        serial_reset_done;
  logic [1:0]  db_estado;

  ws2811_serial_tx dut (
    .clock             (clock),
    .reset             (reset),
    .send_data         (send_data),
    .serial_reset      (serial_reset),
    .data              (data),
    .dout              (dout),
    .word_sent         (word_sent),
    .serial_reset_done (serial_reset_done),
    .db_estado         (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct { logic [23:0] data; int drop_at; int exp_high; } vec_t;
  typedef struct { int rise; int width; } pulse_t;

  bit          sd_arr [NLOG];
  bit          sr_arr [NLOG];
  logic [23:0] dt_arr [NLOG];
  logic        dout_log [NLOG];
  logic        ws_log [NLOG];
  logic        done_log [NLOG];
  logic [1:0]  st_log [NLOG];
  pulse_t      sb [$];
  vec_t        vecs [4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int n = 0; n < NLOG; n++) begin
      sd_arr[n] = 1'b0; sr_arr[n] = 1'b0; dt_arr[n] = '0;
      dout_log[n] = 1'b0; ws_log[n] = 1'b0; done_log[n] = 1'b0; st_log[n] = 2'b00;
    end
  endtask

  // Cycle 0 carries the inputs sampled at E0; cycle n is logged at its negedge.
  // With ctl set, send_data follows a controller model: SendSerial until word_sent,
  // one NextLed cycle low, then SendSerial again while words remain.
  task automatic run(input int ncyc, input bit ctl, input int nwords);
    int cst;
    int sent;
    cst = 0;
    sent = 0;
    for (int n = 0; n <= ncyc; n++) begin
      @(negedge clock);
      if (n > 0) begin
        dout_log[n] = dout; ws_log[n] = word_sent;
        done_log[n] = serial_reset_done; st_log[n] = db_estado;
      end
      if (ctl && n > 0) begin
        if (cst == 0 && ws_log[n-1]) begin
          cst = 1;
          sent++;
        end else if (cst == 1) begin
          cst = (sent < nwords) ? 0 : 2;
        end
      end
      send_data    = ctl ? (cst == 0) : sd_arr[n];
      serial_reset = sr_arr[n];
      data         = dt_arr[n];
    end
  endtask

  // Scoreboard: expected pulses pushed from the word, popped on each falling edge.
  task automatic check_word(input logic [23:0] d, input int e0, input string tag, output int hi);
    pulse_t p;
    int rise_n, nws, ndone, npulses;
    for (int k = 23; k >= 0; k--) begin
      p.rise  = e0 + (23 - k) * BITC + 1;
      p.width = d[k] ? T1H : T0H;
      sb.push_back(p);
    end
    rise_n = 0; nws = 0; ndone = 0; npulses = 0; hi = 0;
    for (int n = e0 + 1; n <= e0 + 24 * BITC; n++) begin
      if (dout_log[n]) hi++;
      if (ws_log[n]) nws++;
      if (done_log[n]) ndone++;
      if (dout_log[n] && !dout_log[n-1]) rise_n = n;
      if (!dout_log[n] && dout_log[n-1]) begin
        if (sb.size() > 0) begin
          p = sb.pop_front();
          chk($sformatf("%s_rise_bit%0d", tag, 23 - npulses), rise_n - e0, p.rise - e0);
          chk($sformatf("%s_width_bit%0d", tag, 23 - npulses), n - rise_n, p.width);
        end
        npulses++;
      end
    end
    chk({tag, "_pulse_count"}, npulses, 24);
    chk({tag, "_pulses_left"}, sb.size(), 0);
    sb.delete();
    chk({tag, "_state_bit"}, int'(st_log[e0 + 1]), 1);
    chk({tag, "_word_sent_at_1512"}, int'(ws_log[e0 + 24 * BITC]), 1);
    chk({tag, "_word_sent_count"}, nws + int'(ws_log[e0 + 24 * BITC + 1]), 1);
    chk({tag, "_no_latch_done"}, ndone, 0);
    chk({tag, "_idle_at_1513"}, int'(st_log[e0 + 24 * BITC + 1]), 0);
  endtask

  initial begin
    int hi, cnt;
    logic [23:0] w1, w2;

    vecs[0] = '{24'hA50F81, 9999, 680};
    vecs[1] = '{24'h000000, 9999, 480};
    vecs[2] = '{24'hFFFFFF, 9999, 960};
    vecs[3] = '{24'h123456, 200,  660};

    reset = 1'b1; send_data = 1'b0; serial_reset = 1'b0; data = '0;
    repeat (3) @(negedge clock);
    chk("reset_dout", int'(dout), 0);
    chk("reset_word_sent", int'(word_sent), 0);
    chk("reset_done", int'(serial_reset_done), 0);
    chk("reset_state", int'(db_estado), 0);
    reset = 1'b0;

    // Single words: send_data held to word_sent or dropped early; data scrambled after load.
    for (int i = 0; i < 4; i++) begin
      clear_all();
      for (int n = 0; n <= 1520; n++) begin
        sd_arr[n] = (n <= 24 * BITC) && (n < vecs[i].drop_at);
        dt_arr[n] = (n == 0) ? vecs[i].data : ~vecs[i].data;
      end
      run(1520, 1'b0, 0);
      check_word(vecs[i].data, 0, $sformatf("vec%0d", i), hi);
      chk($sformatf("vec%0d_high_total", i), hi, vecs[i].exp_high);
    end

    // Back-to-back words through the controller model; data changes during NextLed.
    clear_all();
    w1 = 24'hC3A5F0;
    w2 = 24'h5A0F3C;
    for (int n = 0; n < NLOG; n++) dt_arr[n] = (n < 1513) ? w1 : ((n < 1515) ? w2 : ~w2);
    run(3040, 1'b1, 2);
    check_word(w1, 0, "b2b_w1", hi);
    check_word(w2, 1514, "b2b_w2", hi);
    chk("b2b_gap_low", int'(dout_log[1513]) + int'(dout_log[1514]), 0);

    // Full latch period.
    clear_all();
    for (int n = 0; n <= RSTC; n++) sr_arr[n] = 1'b1;
    run(3010, 1'b0, 0);
    cnt = 0;
    hi = 0;
    for (int n = 1; n <= 3010; n++) begin
      cnt += int'(done_log[n]);
      hi  += int'(dout_log[n]) + int'(ws_log[n]);
    end
    chk("latch_state", int'(st_log[1]), 2);
    chk("latch_no_early_done", int'(done_log[RSTC - 1]), 0);
    chk("latch_done_at_3000", int'(done_log[RSTC]), 1);
    chk("latch_done_count", cnt, 1);
    chk("latch_dout_low", hi, 0);
    chk("latch_still_latch_3000", int'(st_log[RSTC]), 2);
    chk("latch_idle_3001", int'(st_log[RSTC + 1]), 0);

    // Latch aborted at cycle 1000.
    clear_all();
    for (int n = 0; n < 1000; n++) sr_arr[n] = 1'b1;
    run(1010, 1'b0, 0);
    cnt = 0;
    for (int n = 1; n <= 1010; n++) cnt += int'(done_log[n]);
    chk("abort_latch_1000", int'(st_log[1000]), 2);
    chk("abort_idle_1001", int'(st_log[1001]), 0);
    chk("abort_no_done", cnt, 0);

    // serial_reset wins over send_data in Idle.
    clear_all();
    for (int n = 0; n <= 5; n++) sr_arr[n] = 1'b1;
    for (int n = 0; n <= 3; n++) sd_arr[n] = 1'b1;
    run(10, 1'b0, 0);
    hi = 0;
    for (int n = 1; n <= 10; n++) hi += int'(dout_log[n]);
    chk("prio_latch", int'(st_log[1]), 2);
    chk("prio_latch_6", int'(st_log[6]), 2);
    chk("prio_idle_7", int'(st_log[7]), 0);
    chk("prio_dout_low", hi, 0);

    // Asynchronous reset 100 cycles into a word.
    clear_all();
    for (int n = 0; n <= 100; n++) begin
      sd_arr[n] = 1'b1;
      dt_arr[n] = 24'hFFFFFF;
    end
    run(100, 1'b0, 0);
    chk("midrst_pre_dout", int'(dout_log[100]), 1);
    reset = 1'b1;
    send_data = 1'b0;
    #1;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_word_sent", int'(word_sent), 0);
    chk("midrst_done", int'(serial_reset_done), 0);
    chk("midrst_state", int'(db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    clear_all();
    run(20, 1'b0, 0);
    hi = 0;
    for (int n = 1; n <= 20; n++)
      hi += int'(dout_log[n]) + int'(ws_log[n]) + int'(done_log[n]) + int'(st_log[n]);
    chk("postrst_quiet", hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2811_serial_tx.md
# ws2811_serial_tx

Serial bit encoder for the WS2811 LED chain. It sits directly downstream of the array controller FSM. It consumes that FSM's `send_data` / `serial_reset` levels and the current 24-bit LED word, drives the single-wire data line, and returns the `word_sent` / `serial_reset_done` pulses the FSM waits on. All pulse widths are parameterised in clock cycles; the defaults assume a 50 MHz clock and 800 kHz WS2811 signalling.

## Interface
- `T0H_CYCLES`, 20: high time of a 0 bit (0.40 µs).
- `T1H_CYCLES`, 40: high time of a 1 bit (0.80 µs).
- `BIT_CYCLES`, 63: full bit period (1.26 µs). Legal ordering is 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES.
- `RESET_CYCLES`, 3000: latch/reset low time (60 µs).
- `clock`  in  1  system clock; every register is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `send_data`  in  1  level from the controller; request to transmit `data`.
- `serial_reset`  in  1  level from the controller; request a latch low period.
- `data`  in  24  LED word, MSB first on the wire. Colour byte order is the upstream's concern.
- `dout`  out  1  registered serial line to the first LED.
- `word_sent`  out  1  one-cycle pulse marking the end of a 24-bit word.
- `serial_reset_done`  out  1  one-cycle pulse marking the end of a latch period.
- `db_estado`  out  2  current state, for debug.

## Operation
- There are three states: Idle (00), Bit (01) and Latch (10). Encoding 11 is illegal and returns to Idle on the next edge.
- Internal registers:
  - 24-bit shift register.
  - 5-bit bit counter (23 down to 0).
  - Cycle counter of width $clog2(max(BIT_CYCLES, RESET_CYCLES)).
- Idle:
  - `dout` = 0.
  - If `serial_reset` = 1, go to Latch. `serial_reset` has priority over `send_data`.
  - Otherwise, if `send_data` = 1: load `data` into the shift register, set the bit counter to 23, clear the cycle counter, and go to Bit.
- Bit:
  - The cycle counter runs from 0 to BIT_CYCLES-1.
  - `dout` = 1 while cycle counter < T_H, else 0. T_H is T1H_CYCLES if the shift-register MSB = 1, otherwise T0H_CYCLES.
  - When the cycle counter reaches BIT_CYCLES-1:
    - If the bit counter ≠ 0: shift left, decrement the bit counter, clear the cycle counter.
    - If the bit counter = 0: assert `word_sent` in that same cycle and go to Idle.
  - `send_data` is ignored once the word has started. Deasserting it mid-word does not truncate the word, and `word_sent` still pulses.
  - `data` is sampled only at the load edge; later changes have no effect on the word in flight.
- Latch:
  - `dout` = 0. The cycle counter runs from 0 to RESET_CYCLES-1.
  - At RESET_CYCLES-1, assert `serial_reset_done` for that cycle and go to Idle.
  - If `serial_reset` drops before the count completes, abort to Idle on the next edge with no `serial_reset_done` pulse.
  - If `serial_reset` is still high after completion, a new full latch period starts from Idle.
- `word_sent` and `serial_reset_done` are never asserted in the same cycle, and never for more than one cycle.

## Timing
- Reset values: `dout` = 0, `word_sent` = 0, `serial_reset_done` = 0, `db_estado` = 00. The shift register and both counters reset to 0.
- Asynchronous reset mid-word or mid-latch forces `dout` low immediately; no completion pulse is issued.
- Word timing, with E0 the edge at which Idle samples `send_data` = 1:
  - Bit k (k = 23..0) occupies cycles (23-k)·BIT_CYCLES+1 through (24-k)·BIT_CYCLES after E0.
  - `dout` rises in cycle 1.
  - `word_sent` is high during cycle 24·BIT_CYCLES (1512 with defaults); Idle is entered in cycle 1513.
- Handshake with the controller:
  - The controller leaves SendSerial on `word_sent` and spends one cycle in NextLed with `send_data` low.
  - The next load therefore samples at cycle 1514 and `dout` rises at 1515. The last low of the previous word is stretched by 2 cycles (40 ns), well within WS2811 tolerance.
- Latch timing: with E0 the edge at which Idle samples `serial_reset` = 1, `serial_reset_done` is high in cycle RESET_CYCLES and Idle is entered in cycle RESET_CYCLES+1.
- `dout` is registered, so it has zero-cycle skew relative to `db_estado` changes.

## Test plan
- **Reset:** assert `reset` mid-word, 100 cycles into the word → `dout`, `word_sent`, `serial_reset_done` = 0 and `db_estado` = 00 immediately. After release, with no requests, all outputs stay 0.
- **Mixed word:** `data` = 24'hA50F81, `send_data` held high until `word_sent` → the 24 high pulses are 40 cycles (1 bits) or 20 cycles (0 bits) in MSB-first order 1010_0101_0000_1111_1000_0001. Each period is 63 cycles and `word_sent` is a single pulse at cycle 1512.
- **Extreme words:** 24'h000000 → 24 pulses, each 20 high / 43 low. 24'hFFFFFF → 24 pulses, each 40 high / 23 low.
- **Back-to-back with controller model:** two words → the second word's first rising edge is at cycle 1515. `data` changed during NextLed is captured correctly.
- **Latch period:** `serial_reset` held → `dout` low for 3000 cycles and `serial_reset_done` pulses at cycle 3000. Drop `serial_reset` at cycle 1000 → no pulse, Idle at cycle 1001.
- **Priority and early release:** `serial_reset` and `send_data` both high in Idle → Latch is entered. `send_data` dropped at cycle 200 of a word → all 24 bits still sent and `word_sent` still pulses at cycle 1512.
